// File: rtl/trigger_capture_if.sv
// -----------------------------------------------------------------------------
// trigger_capture_if
// Bundles the sample stream, trigger controls, record read port and status
// flags of the trigger capture stage.
//   master : drives sample_valid/sample, arm, trig_level, trig_slope,
//            force_trig, rd_en; observes rd_data, rd_valid, armed,
//            triggered, done.
//   slave  : the capture stage itself (mirror image of master).
// -----------------------------------------------------------------------------
interface trigger_capture_if;
   logic        sample_valid;
   logic [11:0] sample;
   logic        arm;
   logic [11:0] trig_level;
   logic        trig_slope;
   logic        force_trig;
   logic        rd_en;
   logic [11:0] rd_data;
   logic        rd_valid;
   logic        armed;
   logic        triggered;
   logic        done;

   modport master (
      output sample_valid, sample, arm, trig_level, trig_slope, force_trig, rd_en,
      input  rd_data, rd_valid, armed, triggered, done
   );

   modport slave (
      input  sample_valid, sample, arm, trig_level, trig_slope, force_trig, rd_en,
      output rd_data, rd_valid, armed, triggered, done
   );
endinterface

// File: rtl/trigger_capture.sv
// -----------------------------------------------------------------------------
// trigger_capture
// Pre/post-trigger capture of 12-bit ADC samples into a circular buffer.
// A capture starts on arm, fills PRETRIG history samples, waits for a
// level/slope crossing (or force_trig), stores DEPTH-PRETRIG samples from the
// trigger onward, then freezes the record and reads it out oldest-first.
//
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : trigger_capture_if.slave
//             sample_valid/sample  - one-cycle sample strobes
//             arm                  - start/restart a capture
//             trig_level/slope     - trigger threshold and edge select
//             force_trig           - next WAIT_TRIG sample is the trigger
//             rd_en                - read one record word (DONE only)
//             rd_data/rd_valid     - read data, one cycle after rd_en
//             armed/triggered/done - registered state flags
// -----------------------------------------------------------------------------
module trigger_capture #(
   parameter int DEPTH   = 256,
   parameter int PRETRIG = 64
) (
   input  logic              clk,
   input  logic              reset,
   trigger_capture_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW-1:0] PRE_CNT  = AW'(PRETRIG);
   localparam logic [AW-1:0] POST_LEN = AW'(DEPTH - PRETRIG);
   localparam logic [AW-1:0] LAST_RD  = AW'(DEPTH - 1);
   localparam logic [AW-1:0] ONE      = AW'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREFILL,
      ST_WAIT_TRIG,
      ST_POST,
      ST_DONE
   } state_t;

   state_t state_q, state_d;

   logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0] cnt_q,      cnt_d;
   logic [AW-1:0] trig_ptr_q, trig_ptr_d;
   logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
   logic [AW-1:0] rd_cnt_q,   rd_cnt_d;
   logic [11:0]   prev_q,     prev_d;
   logic          rd_valid_q, rd_valid_d;
   logic          armed_q,    armed_d;
   logic          triggered_q, triggered_d;
   logic          done_q,     done_d;

   // Record buffer: one write port (sample path), one registered read port.
   logic [11:0]   mem [DEPTH];
   logic [11:0]   mem_rd_q;

   logic          wr_en;
   logic          rd_accept;
   logic          rising_hit;
   logic          falling_hit;
   logic          trig_hit;
   logic [AW-1:0] cnt_inc;

   // arm takes priority over everything: a strobe or read in the arm cycle
   // is discarded.
   assign wr_en = bus.sample_valid && !bus.arm &&
                  (state_q inside {ST_PREFILL, ST_WAIT_TRIG, ST_POST});

   assign rd_accept = bus.rd_en && !bus.arm && (state_q == ST_DONE);

   // Equality with the level only counts as a crossing when coming from the
   // strict side, so a signal parked on the level never triggers.
   assign rising_hit  = (prev_q < bus.trig_level) && (bus.sample >= bus.trig_level);
   assign falling_hit = (prev_q > bus.trig_level) && (bus.sample <= bus.trig_level);

   assign trig_hit = wr_en && (state_q == ST_WAIT_TRIG) &&
                     (bus.force_trig || (bus.trig_slope ? rising_hit : falling_hit));

   assign cnt_inc = cnt_q + ONE;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (bus.arm) begin
         state_d = ST_PREFILL;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_PREFILL: begin
               if (wr_en && (cnt_inc == PRE_CNT)) begin
                  state_d = ST_WAIT_TRIG;
               end
            end
            ST_WAIT_TRIG: begin
               // With a single post-trigger sample the record is complete
               // as soon as the trigger sample lands.
               if (trig_hit) begin
                  state_d = (POST_LEN == ONE) ? ST_DONE : ST_POST;
               end
            end
            ST_POST: begin
               if (wr_en && (cnt_inc == POST_LEN)) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (rd_accept && (rd_cnt_q == LAST_RD)) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: registered output flags, derived from the next state so they line
   // up with the state register.
   // ---------------------------------------------------------------------------
   always_comb begin
      armed_d     = (state_d == ST_PREFILL) || (state_d == ST_WAIT_TRIG);
      triggered_d = (state_d == ST_POST) || (state_d == ST_DONE);
      done_d      = (state_d == ST_DONE);
   end

   // ---------------------------------------------------------------------------
   // Datapath: pointers, counters, previous sample
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      cnt_d      = cnt_q;
      trig_ptr_d = trig_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rd_cnt_d   = rd_cnt_q;
      prev_d     = prev_q;
      rd_valid_d = rd_accept;

      if (bus.arm) begin
         wr_ptr_d = '0;
         cnt_d    = '0;
         rd_cnt_d = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ONE;
            prev_d   = bus.sample;
            // cnt only tracks progress in PREFILL and POST; it is reloaded
            // on the trigger.
            if (state_q != ST_WAIT_TRIG) begin
               cnt_d = cnt_inc;
            end
         end

         if (trig_hit) begin
            trig_ptr_d = wr_ptr_q;
            cnt_d      = ONE;
         end

         if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + ONE;
            rd_cnt_d = rd_cnt_q + ONE;
         end

         // On entry to DONE point the reader at the oldest pre-trigger sample.
         if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            rd_ptr_d = trig_ptr_d - PRE_CNT;
            rd_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         cnt_q       <= '0;
         trig_ptr_q  <= '0;
         rd_ptr_q    <= '0;
         rd_cnt_q    <= '0;
         prev_q      <= '0;
         rd_valid_q  <= 1'b0;
         armed_q     <= 1'b0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         trig_ptr_q  <= trig_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_cnt_q    <= rd_cnt_d;
         prev_q      <= prev_d;
         rd_valid_q  <= rd_valid_d;
         armed_q     <= armed_d;
         triggered_q <= triggered_d;
         done_q      <= done_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Buffer RAM (no reset so it maps onto block RAM)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= bus.sample;
      end
      if (rd_accept) begin
         mem_rd_q <= mem[rd_ptr_q];
      end
   end

   // rd_data is forced to zero whenever it is not valid, which also gives the
   // zero value under reset without resetting the RAM output register.
   assign bus.rd_data   = rd_valid_q ? mem_rd_q : 12'h000;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.armed     = armed_q;
   assign bus.triggered = triggered_q;
   assign bus.done      = done_q;

endmodule

// File: doc/trigger_capture.md
# trigger_capture

Capture stage directly downstream of the ADC SPI master in the MicrOscope datapath. It receives 12-bit ADC samples as one-cycle strobes and holds a circular pre-trigger history. On a level/slope trigger crossing (or a forced trigger) it completes one DEPTH-sample record. The record is then frozen and read out oldest-first, starting PRETRIG samples before the trigger, for the display/host side.

## Interface
Parameters:
- DEPTH, 256: record length in samples; power of 2, ≥ 8.
- PRETRIG, 64: samples kept before the trigger sample; 1 ≤ PRETRIG ≤ DEPTH-1.

Ports:
- clk, in, 1: system clock (onboard oscillator domain).
- reset, in, 1: asynchronous, active-low reset.
- sample_valid, in, 1: one-cycle strobe, synchronous to clk; strobes are at least 2 cycles apart.
- sample, in, 12: ADC output code, unsigned; valid only with sample_valid.
- arm, in, 1: one-cycle pulse that starts (or restarts) a capture.
- trig_level, in, 12: unsigned trigger threshold; sampled every compare, not latched.
- trig_slope, in, 1: 1 selects rising edge, 0 selects falling edge.
- force_trig, in, 1: level-sensitive; treats the next valid sample in WAIT_TRIG as the trigger.
- rd_en, in, 1: read request, honoured only in DONE.
- rd_data, out, 12: record word.
- rd_valid, out, 1: rd_data is valid this cycle.
- armed, out, 1: high in PREFILL and WAIT_TRIG.
- triggered, out, 1: high in POST and DONE.
- done, out, 1: high in DONE (record frozen, readable).

## Operation
- States: IDLE, PREFILL, WAIT_TRIG, POST, DONE.
- IDLE: samples ignored. On arm: clear wr_ptr and cnt, go to PREFILL.
- PREFILL: each valid sample is written at wr_ptr, wr_ptr++ (mod DEPTH), cnt++. When the PRETRIG-th sample is written, go to WAIT_TRIG. No trigger compare in this state, but prev is updated on every write.
- WAIT_TRIG: each valid sample is written circularly.
  - Rising trigger: prev < trig_level and sample ≥ trig_level.
  - Falling trigger: prev > trig_level and sample ≤ trig_level.
  - On trigger (or force_trig high at the strobe): the trigger sample is written, trig_ptr = its address, cnt = 1, go to POST.
- POST: each valid sample is written. When cnt reaches DEPTH-PRETRIG, go to DONE. Total post-trigger samples including the trigger sample = DEPTH-PRETRIG.
- DONE: writes are blocked and samples are ignored.
  - Entering DONE sets rd_ptr = (trig_ptr - PRETRIG) mod DEPTH and rd_cnt = 0.
  - Each rd_en reads one word: rd_ptr++, rd_cnt++.
  - After the DEPTH-th read is accepted, go to IDLE. done falls the cycle after the last accepted rd_en.
- Arithmetic: all pointers are log2(DEPTH) bits and wrap naturally. Compares are unsigned 12-bit.
- Boundary rules:
  - arm in any state (including mid-readout) restarts at PREFILL. A sample_valid in the same cycle as arm is discarded.
  - rd_en outside DONE is ignored; rd_valid stays 0.
  - The trigger compare equal-to-level counts as crossed only from the strict side (see the conditions above).
  - Reset mid-operation returns to IDLE immediately. Buffer contents are not cleared; they are don't-care.

## Timing
- Reset values: state IDLE, armed 0, triggered 0, done 0, rd_valid 0, rd_data 0, all pointers/counters 0.
- Buffer is a synchronous-read RAM (block RAM inferable): one write port (sample path), one read port.
- Read latency: rd_en in cycle n gives rd_data/rd_valid in cycle n+1. rd_valid is high for exactly one cycle per accepted rd_en. Back-to-back rd_en every cycle gives one word per cycle.
- Write path: a sample strobed in cycle n is in RAM and reflected in state/flags at cycle n+1.
- State flags are registered. The POST→DONE transition is visible one cycle after the final post-trigger strobe.

## Test plan
Bench configuration: DEPTH=16, PRETRIG=4 unless noted.

- Basic rising trigger: trig_level=0x100, slope=1; arm, then feed 0x0F0, 0x0F4, … step 4.
  - Trigger on 0x100. done asserts after 0x12C.
  - 16 back-to-back reads return 0x0F0…0x12C step 4, each 1 cycle after its rd_en. After the last read, IDLE is reached and done=0.
- Wrap-around: sample k = k for k<40, sample k = 0x200+(k-40) for k≥40; level 0x100.
  - Readout is 0x024, 0x025, 0x026, 0x027, then 0x200…0x20B.
- Falling slope plus no-false-trigger: slope=0, level=0x080.
  - Hold 0x080 for 10 samples: no trigger (prev not > level).
  - Then 0x090, 0x07F: trigger on 0x07F. Record[PRETRIG]=0x07F.
- Forced trigger: constant 0x055 in WAIT_TRIG, pulse force_trig.
  - The next sample becomes the trigger. Record is 16×0x055 and triggered rises 1 cycle after that strobe.
- Abort/reset: arm mid-POST with sample_valid in the same cycle.
  - The sample is dropped, state returns to PREFILL, and the new record holds only post-arm samples.
  - Assert reset mid-readout: all outputs go to 0 asynchronously; rd_en is ignored afterwards until a new capture completes.
